// File: rtl/payout_pkg.sv
// Shared types and coin values for the change payout controller.
package payout_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    VEND        = 3'd1,
    VEND_WAIT   = 3'd2,
    DIME        = 3'd3,
    DIME_WAIT   = 3'd4,
    NICKEL      = 3'd5,
    NICKEL_WAIT = 3'd6,
    FAULT       = 3'd7
  } state_e;

  localparam int NICKEL_CENTS = 5;
  localparam int DIME_CENTS   = 10;

endpackage

// File: rtl/payout_timer.sv
// Acknowledge-wait timeout counter: counts enabled cycles since the last clear
// and flags the last cycle allowed before a timeout.
module payout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count_q, count_d;

  // expired marks the final waiting cycle, so the owner leaves after exactly
  // TIMEOUT_CYCLES unacknowledged cycles.
  assign expired = enable && (count_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/change_payout_ctrl.sv
// Vend/change payout sequencer: queues vend and coin-return requests and
// services them one at a time with ack-timed handshakes.
// Optional macro PAYOUT_TOTAL_EN enables the paid_cents running total.
module change_payout_ctrl
  import payout_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Dispense,
  input  logic             ReturnNickel,
  input  logic             ReturnDime,
  input  logic             ReturnTwoDimes,
  input  logic             vend_done,
  input  logic             coin_sensed,
  output logic             vend_motor,
  output logic             dime_eject,
  output logic             nickel_eject,
  output logic             busy,
  output logic             fault,
  output logic [7:0]       paid_cents,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] dime_cnt_o,
  output logic [CNT_W-1:0] nickel_cnt_o,
  output logic             vend_pend_o
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dime_q, dime_d, nickel_q, nickel_d;
  logic             vend_pend_q, vend_pend_d;
  logic             fault_q, fault_d;
  logic             vend_motor_q, dime_eject_q, nickel_eject_q;
  logic             vend_ack, dime_ack, nickel_ack;
  logic             in_wait, expired;
  logic [SW-1:0]    dime_sum, nickel_sum;
  logic             dime_ovf, nickel_ovf;

  // Acks only count while the matching handshake is outstanding.
  assign vend_ack   = (state_q == VEND_WAIT)   && vend_done;
  assign dime_ack   = (state_q == DIME_WAIT)   && coin_sensed;
  assign nickel_ack = (state_q == NICKEL_WAIT) && coin_sensed;
  assign in_wait    = (state_q == VEND_WAIT) || (state_q == DIME_WAIT) ||
                      (state_q == NICKEL_WAIT);

  payout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  // New requests and the ack-time consumption net out in one step; anything
  // beyond the counter ceiling is dropped and flagged.
  always_comb begin
    dime_sum    = SW'(dime_q) + SW'({ReturnTwoDimes, ReturnDime}) - SW'(dime_ack);
    nickel_sum  = SW'(nickel_q) + SW'(ReturnNickel) - SW'(nickel_ack);
    dime_ovf    = dime_sum > CNT_MAX;
    nickel_ovf  = nickel_sum > CNT_MAX;
    dime_d      = dime_ovf ? CNT_MAX[CNT_W-1:0] : dime_sum[CNT_W-1:0];
    nickel_d    = nickel_ovf ? CNT_MAX[CNT_W-1:0] : nickel_sum[CNT_W-1:0];
    vend_pend_d = Dispense || (vend_pend_q && !vend_ack);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (vend_pend_q) begin
          state_d = VEND;
        end else if (dime_q != '0) begin
          state_d = DIME;
        end else if (nickel_q != '0) begin
          state_d = NICKEL;
        end
      end
      VEND:        state_d = VEND_WAIT;
      DIME:        state_d = DIME_WAIT;
      NICKEL:      state_d = NICKEL_WAIT;
      VEND_WAIT:   state_d = vend_done   ? IDLE : (expired ? FAULT : VEND_WAIT);
      DIME_WAIT:   state_d = coin_sensed ? IDLE : (expired ? FAULT : DIME_WAIT);
      NICKEL_WAIT: state_d = coin_sensed ? IDLE : (expired ? FAULT : NICKEL_WAIT);
      FAULT:       state_d = FAULT;
      default:     state_d = IDLE;
    endcase
  end

  assign fault_d = fault_q || dime_ovf || nickel_ovf || (state_d == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      dime_q         <= '0;
      nickel_q       <= '0;
      vend_pend_q    <= 1'b0;
      fault_q        <= 1'b0;
      vend_motor_q   <= 1'b0;
      dime_eject_q   <= 1'b0;
      nickel_eject_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dime_q         <= dime_d;
      nickel_q       <= nickel_d;
      vend_pend_q    <= vend_pend_d;
      fault_q        <= fault_d;
      vend_motor_q   <= (state_d == VEND);
      dime_eject_q   <= (state_d == DIME);
      nickel_eject_q <= (state_d == NICKEL);
    end
  end

`ifdef PAYOUT_TOTAL_EN
  logic [7:0] paid_q, paid_d;

  always_comb begin
    paid_d = paid_q;
    if (dime_ack) begin
      paid_d = paid_q + 8'(DIME_CENTS);
    end else if (nickel_ack) begin
      paid_d = paid_q + 8'(NICKEL_CENTS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paid_q <= 8'd0;
    end else begin
      paid_q <= paid_d;
    end
  end

  assign paid_cents = paid_q;
`else
  assign paid_cents = 8'd0;
`endif

  // A latched fault parks the machine, so pending work no longer counts as busy.
  assign busy = ((state_q != IDLE) && (state_q != FAULT)) ||
                ((state_q == IDLE) && (vend_pend_q || (dime_q != '0) || (nickel_q != '0)));

  assign vend_motor   = vend_motor_q;
  assign dime_eject   = dime_eject_q;
  assign nickel_eject = nickel_eject_q;
  assign fault        = fault_q;
  assign state_o      = state_q;
  assign dime_cnt_o   = dime_q;
  assign nickel_cnt_o = nickel_q;
  assign vend_pend_o  = vend_pend_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Self-checking bench for change_payout_ctrl: directed scenarios with a pulse
// scoreboard ({kind, cycle}) checked by an independent monitor.
module tb_change_payout_ctrl;

  localparam int TO = 8;
  localparam int CW = 3;
  localparam int W  = 20;

`ifdef PAYOUT_TOTAL_EN
  localparam int DIME_C = 10;
`else
  localparam int DIME_C = 0;
`endif

  localparam logic [1:0] K_VEND   = 2'd1;
  localparam logic [1:0] K_DIME   = 2'd2;
  localparam logic [1:0] K_NICKEL = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Dispense = 1'b0, ReturnNickel = 1'b0, ReturnDime = 1'b0, ReturnTwoDimes = 1'b0;
  logic          vend_done = 1'b0, coin_sensed = 1'b0;
  logic          vend_motor, dime_eject, nickel_eject, busy, fault;
  logic [7:0]    paid_cents;
  logic [2:0]    state_o;
  logic [CW-1:0] dime_cnt_o, nickel_cnt_o;
  logic          vend_pend_o;

  logic [W-1:0]  exp_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic          ack_en = 1'b0;
  int            ack_delay = 0;
  int            stray_req = 0;

  change_payout_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Dispense      (Dispense),
    .ReturnNickel  (ReturnNickel),
    .ReturnDime    (ReturnDime),
    .ReturnTwoDimes(ReturnTwoDimes),
    .vend_done     (vend_done),
    .coin_sensed   (coin_sensed),
    .vend_motor    (vend_motor),
    .dime_eject    (dime_eject),
    .nickel_eject  (nickel_eject),
    .busy          (busy),
    .fault         (fault),
    .paid_cents    (paid_cents),
    .state_o       (state_o),
    .dime_cnt_o    (dime_cnt_o),
    .nickel_cnt_o  (nickel_cnt_o),
    .vend_pend_o   (vend_pend_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, cycle=%0d required=<10000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic d, input logic n, input logic dm, input logic td);
    Dispense = d; ReturnNickel = n; ReturnDime = dm; ReturnTwoDimes = td;
    @(posedge clk);
    #1;
    Dispense = 1'b0; ReturnNickel = 1'b0; ReturnDime = 1'b0; ReturnTwoDimes = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_pulse(input logic [1:0] kind, input int c);
    exp_q.push_back({kind, 18'(c)});
  endtask

  // Hopper/motor model: acks ack_delay cycles into the WAIT that follows a
  // pulse; stray_req requests one unsolicited ack of both kinds.
  initial begin
    int   cnt;
    int   stray_done;
    logic seen;
    logic rk_vend;
    cnt = 0; stray_done = 0; rk_vend = 1'b0;
    forever begin
      @(negedge clk);
      seen = !reset && (vend_motor || dime_eject || nickel_eject);
      if (seen) rk_vend = vend_motor;
      @(posedge clk);
      #1;
      vend_done   = 1'b0;
      coin_sensed = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (seen && ack_en) cnt = ack_delay + 1;
        if (stray_req != stray_done) begin
          vend_done   = 1'b1;
          coin_sensed = 1'b1;
          stray_done  = stray_req;
        end else if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            if (rk_vend) vend_done = 1'b1;
            else         coin_sensed = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [2:0]   pul, prev;
    logic [1:0]   kind;
    logic [W-1:0] e, got;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 3'b000;
      end else begin
        pul = {vend_motor, dime_eject, nickel_eject};
        if (pul != 3'b000) begin
          kind = (pul == 3'b100) ? K_VEND : (pul == 3'b010) ? K_DIME :
                 (pul == 3'b001) ? K_NICKEL : 2'd0;
          got = {kind, 18'(cyc)};
          checks++;
          if ((pul & prev) != 3'b000) begin
            failures++;
            $display("FAIL pulse_repeat: pulses=%b previous=%b required no repeat (cycle %0d)", pul, prev, cyc);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: pulses=%b at cycle %0d, none expected", pul, cyc);
          end else begin
            e = exp_q.pop_front();
            if (got != e) begin
              failures++;
              $display("FAIL pulse_event: got kind=%0d cycle=%0d expected kind=%0d cycle=%0d",
                       got[W-1:W-2], got[17:0], e[W-1:W-2], e[17:0]);
            end
          end
        end
        prev = pul;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_paid", paid_cents, 0);
    check("rst_pulses", {vend_motor, dime_eject, nickel_eject}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Vend plus two dimes; every ack three cycles into its WAIT.
    ack_en = 1'b1; ack_delay = 3;
    n = cyc;
    expect_pulse(K_VEND, n + 2);
    expect_pulse(K_DIME, n + 8);
    expect_pulse(K_DIME, n + 14);
    strobe(1'b1, 1'b0, 1'b0, 1'b1);
    check("a_vend_pend", vend_pend_o, 1);
    check("a_dime_cnt", dime_cnt_o, 2);
    check("a_busy", busy, 1);
    wait_until(n + 18);
    check("a_busy_last_wait", busy, 1);
    check("a_dime_cnt_last_wait", dime_cnt_o, 1);
    wait_until(n + 19);
    check("a_busy_done", busy, 0);
    check("a_dime_cnt_done", dime_cnt_o, 0);
    check("a_vend_pend_done", vend_pend_o, 0);
    check("a_paid", paid_cents, 2 * DIME_C);

    // Acks outside a WAIT state are ignored.
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    check("b_stray_state", state_o, 0);
    check("b_stray_paid", paid_cents, 2 * DIME_C);
    check("b_stray_busy", busy, 0);
    do_reset();
    check("b_paid_after_reset", paid_cents, 0);

    // New dime arriving in the same cycle its predecessor is acknowledged.
    ack_en = 1'b1; ack_delay = 2;
    n = cyc;
    expect_pulse(K_DIME, n + 2);
    expect_pulse(K_DIME, n + 7);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    wait_until(n + 5);
    check("c_state_ack_cycle", state_o, 4);
    check("c_dime_cnt_ack_cycle", dime_cnt_o, 1);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    check("c_dime_cnt_net", dime_cnt_o, 1);
    check("c_state_idle", state_o, 0);
    wait_until(n + 11);
    check("c_dime_cnt_done", dime_cnt_o, 0);
    check("c_paid", paid_cents, 2 * DIME_C);
    check("c_busy_done", busy, 0);

    // Reset while waiting for a coin: everything clears, nothing follows.
    do_reset();
    ack_en = 1'b0;
    n = cyc;
    expect_pulse(K_DIME, n + 2);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    wait_until(n + 4);
    check("d_state_wait", state_o, 4);
    reset = 1'b1;
    #1;
    check("d_rst_pulses", {vend_motor, dime_eject, nickel_eject}, 0);
    check("d_rst_busy", busy, 0);
    check("d_rst_fault", fault, 0);
    check("d_rst_dime_cnt", dime_cnt_o, 0);
    check("d_rst_state", state_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("d_post_state", state_o, 0);
    check("d_post_busy", busy, 0);

    // Nickel never sensed: FAULT after TO WAIT cycles, count held.
    n = cyc;
    expect_pulse(K_NICKEL, n + 2);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    wait_until(n + 10);
    check("e_state_last_wait", state_o, 6);
    check("e_fault_before", fault, 0);
    wait_until(n + 11);
    check("e_state_fault", state_o, 7);
    check("e_fault", fault, 1);
    check("e_nickel_held", nickel_cnt_o, 1);
    check("e_busy_fault", busy, 0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    check("e_dime_captured", dime_cnt_o, 1);
    repeat (5) @(posedge clk);
    #1;
    check("e_state_stays", state_o, 7);

    // Eight dimes back to back with no acks saturate the counter.
    do_reset();
    check("f_fault_cleared", fault, 0);
    n = cyc;
    expect_pulse(K_DIME, n + 2);
    ReturnDime = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) begin
        check("f_dime_cnt_7th", dime_cnt_o, 7);
        check("f_fault_7th", fault, 0);
      end
    end
    ReturnDime = 1'b0;
    check("f_dime_cnt_sat", dime_cnt_o, 7);
    check("f_fault_8th", fault, 1);
    check("f_state_wait", state_o, 4);
    do_reset();

    repeat (3) @(posedge clk);
    #1;
    check("end_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_payout_ctrl.md
CHANGE_PAYOUT_CTRL -- requirements
Module: change_payout_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles waited for a hopper/motor acknowledge.
REQ-002 Parameter CNT_W, default 3, width of each pending-coin counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 Dispense  input  1  one-cycle strobe, vend one product.
REQ-006 ReturnNickel  input  1  one-cycle strobe, queue one nickel.
REQ-007 ReturnDime  input  1  one-cycle strobe, queue one dime.
REQ-008 ReturnTwoDimes  input  1  one-cycle strobe, queue two dimes.
REQ-009 vend_motor  output  1  one-cycle pulse, start product motor.
REQ-010 vend_done  input  1  motor-complete acknowledge.
REQ-011 dime_eject / nickel_eject  output  1 each  one-cycle hopper eject pulse.
REQ-012 coin_sensed  input  1  exit-chute sensor acknowledge for the last eject.
REQ-013 busy  output  1  high when not IDLE or any work pending.
REQ-014 fault  output  1  sticky timeout/overflow indication.
REQ-015 paid_cents  output  8  running total of change paid (see Configuration).

Function
REQ-016 Strobes shall be captured every cycle: vend_pend set; dime_cnt +1 (ReturnDime), +2 (ReturnTwoDimes), +3 (both); nickel_cnt +1.
REQ-017 Counters shall saturate at 2^CNT_W-1; a request exceeding saturation shall set fault and excess shall be dropped.
REQ-018 Increment and service decrement in the same cycle shall both apply (net value).
REQ-019 FSM states: IDLE, VEND, VEND_WAIT, DIME, DIME_WAIT, NICKEL, NICKEL_WAIT, FAULT.
REQ-020 IDLE priority: vend_pend -> VEND, else dime_cnt!=0 -> DIME, else nickel_cnt!=0 -> NICKEL, else stay.
REQ-021 VEND/DIME/NICKEL shall last exactly one cycle, asserting vend_motor/dime_eject/nickel_eject, then enter the matching WAIT state.
REQ-022 Service item (vend_pend clear or counter -1) shall be consumed on the ack edge, not on the eject.
REQ-023 WAIT exits to IDLE on vend_done (VEND_WAIT) or coin_sensed (coin WAITs); ack outside a WAIT state shall be ignored.
REQ-024 Timeout counter cleared on WAIT entry; reaching TIMEOUT_CYCLES without ack -> FAULT.
REQ-025 FAULT is terminal until reset: no pulses, pending counts held, strobes still captured, busy=0.
REQ-026 Latency: strobe in cycle n, IDLE FSM -> eject/motor pulse high in cycle n+2.
REQ-027 Every pulse output shall be registered, never high two consecutive cycles.

Reset
REQ-028 reset shall force IDLE, clear counters, vend_pend, timer, fault, paid_cents, all outputs 0, mid-handshake included, with no completing pulse after release.

Configuration
REQ-029 Macro PAYOUT_TOTAL_EN defined: paid_cents adds 10 per dime ack, 5 per nickel ack, wraps modulo 256.
REQ-030 Macro undefined: paid_cents tied to 0, accumulator logic absent; port kept.

Structure
REQ-031 Package payout_pkg shall hold the state enum, NICKEL_CENTS=5, DIME_CENTS=10.
REQ-032 Sub-module payout_timer (clear, enable, expired) shall implement the timeout counter.

Verification
REQ-033 Dispense+ReturnTwoDimes same cycle, acks after 3 cycles -> motor at n+2, then two dime_eject pulses, paid_cents=20, busy falls.
REQ-034 ReturnNickel, coin_sensed never asserted, TIMEOUT_CYCLES=8 -> FAULT after 8 WAIT cycles, fault=1, nickel_cnt=1 held.
REQ-035 Eight ReturnDime strobes back-to-back, no acks -> dime_cnt=7, fault=1 on eighth.
REQ-036 ReturnDime during DIME_WAIT ack cycle with dime_cnt=1 -> dime_cnt stays 1, second eject follows.
REQ-037 reset asserted in DIME_WAIT -> all outputs 0 immediately, no eject after release.
REQ-038 Without PAYOUT_TOTAL_EN, scenario REQ-033 -> paid_cents stays 0.
